mem_req_arbiter: RTL and testbench

Shares one sram-like memory port between the instruction-fetch requester and the data requester. The data requester is driven by the EXE-stage `data_sram_*` interface. The block grants one address phase per cycle and holds the grant until the slave accepts it. It records the ID of each accepted request in an in-order FIFO and routes `data_ok`/`rdata` back to the owner. It sits between the pipeline stages and the memory bridge.

---
 rtl/mycpu_mem_pkg.sv | 19 +
 rtl/mem_arb_id_fifo.sv | 57 +++++
 rtl/mem_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_mem_pkg.sv
// Shared definitions for the CPU memory-side blocks: requester IDs, access
// size encodings and common field widths.
package mycpu_mem_pkg;

    localparam int unsigned MEM_SIZE_W = 2;
    localparam int unsigned MEM_STRB_W = 4;

    // Requester ID as recorded in the arbiter's response-order FIFO
    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } mem_id_e;

    // Access size encodings on the sram-like interface
    localparam logic [MEM_SIZE_W-1:0] SIZE_B = 2'b00;
    localparam logic [MEM_SIZE_W-1:0] SIZE_H = 2'b01;
    localparam logic [MEM_SIZE_W-1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered requests.
// Ports:
//   clk, reset       clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_push_id write one ID (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_full/o_empty   occupancy flags
//   o_head           ID of the oldest outstanding request
module mem_arb_id_fifo
    import mycpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  mem_id_e i_push_id,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output mem_id_e o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Pointers carry an extra wrap bit to tell full from empty
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    mem_id_e          r_slots [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head    = r_slots[r_rd_ptr[PTR_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; storage is not reset since it is only read when non-empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_slots[r_wr_ptr[PTR_W-1:0]] <= i_push_id;
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the instruction-fetch and the data
// requester. One address phase is granted per cycle and held until the slave
// accepts it; accepted IDs are queued in order so data_ok/rdata go back to
// their owner.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it data has fixed priority over inst.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   inst_* / data_*              requester sides (req, wr, size, addr, wstrb,
//                                wdata in; addr_ok, data_ok, rdata out)
//   mem_*                        slave side (request fields out; addr_ok,
//                                data_ok, rdata in)
module mem_req_arbiter
    import mycpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OUTST_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [MEM_SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic [MEM_STRB_W-1:0] inst_wstrb,
    input  logic [DATA_W-1:0]     inst_wdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [MEM_SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [MEM_STRB_W-1:0] data_wstrb,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [MEM_SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    logic    w_fifo_full;
    logic    w_fifo_empty;
    mem_id_e w_head;

    logic    r_lock_valid;
    mem_id_e r_lock_id;

    logic    w_inst_elig;
    logic    w_data_elig;
    logic    w_win_valid;
    mem_id_e w_win_id;
    logic    w_accept;
    logic    w_pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_id_e r_rr_last;
`endif

    // Eligibility looks only at the registered full flag, so a same-cycle
    // response never opens a slot and mem_data_ok has no path to mem_req
    assign w_inst_elig = inst_req && !w_fifo_full;
    assign w_data_elig = data_req && !w_fifo_full;

    // Winner select: a held lock wins outright, otherwise arbitrate fresh
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = ID_INST;
        if (r_lock_valid) begin
            w_win_valid = 1'b1;
            w_win_id    = r_lock_id;
        end else if (w_inst_elig && w_data_elig) begin
            w_win_valid = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_win_id    = (r_rr_last == ID_INST) ? ID_DATA : ID_INST;
`else
            w_win_id    = ID_DATA;
`endif
        end else if (w_data_elig) begin
            w_win_valid = 1'b1;
            w_win_id    = ID_DATA;
        end else if (w_inst_elig) begin
            w_win_valid = 1'b1;
            w_win_id    = ID_INST;
        end
    end

    // Request mux toward the slave; all zero when nobody is granted
    always_comb begin
        mem_req   = w_win_valid;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (w_win_valid) begin
            if (w_win_id == ID_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wstrb = inst_wstrb;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign w_accept     = w_win_valid && mem_addr_ok;
    assign inst_addr_ok = w_accept && (w_win_id == ID_INST);
    assign data_addr_ok = w_accept && (w_win_id == ID_DATA);

    // Responses with nothing outstanding (stale after reset) are dropped
    assign w_pop        = mem_data_ok && !w_fifo_empty;
    assign inst_data_ok = w_pop && (w_head == ID_INST);
    assign data_data_ok = w_pop && (w_head == ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    // Grant lock: held while the slave stalls the address phase
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_id    <= ID_INST;
        end else begin
            r_lock_valid <= w_win_valid && !mem_addr_ok;
            r_lock_id    <= w_win_id;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer starts on inst: data counts as last granted, so inst wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= ID_DATA;
        end else if (w_accept) begin
            r_rr_last <= w_win_id;
        end
    end
`endif

    mem_arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_accept),
        .i_push_id (w_win_id),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_head)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: scenario tasks drive the requesters
// and act as the slave; expected responses are queued at acceptance and
// compared when the bench returns mem_data_ok.
module tb_mem_req_arbiter;
    import mycpu_mem_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          inst_req, inst_wr;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic [3:0]    inst_wstrb;
    logic [DW-1:0] inst_wdata;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok, mem_data_ok;
    logic [DW-1:0] mem_rdata;

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OUTST_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          ex_i, ex_d;
    logic [DW-1:0] ex_r;

    // Record an accepted request and the read data the slave will return for it
    task automatic sb_push(input logic id, input logic [DW-1:0] rdata);
        exp_t e;
        e.id    = id;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // One cycle of stimulus; when responding, the slave returns the oldest
    // queued entry and the expected routing is set up from it
    task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
        exp_t e;
        @(negedge clk);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        ex_i        = 1'b0;
        ex_d        = 1'b0;
        ex_r        = '0;
        mem_rdata   = 32'h5A5A_0000 + 32'($urandom_range(0, 255));
        if (dok && sb_q.size() != 0) begin
            e         = sb_q.pop_front();
            mem_rdata = e.rdata;
            ex_r      = e.rdata;
            ex_i      = (e.id == 1'b0);
            ex_d      = (e.id == 1'b1);
        end
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_W; inst_addr = 32'h1C00_0100;
        inst_wstrb = 4'h0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_H; data_addr = 32'h8000_0040;
        data_wstrb = 4'h0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b addr=%h wdata=%h, expected all zero", mem_req, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ok: got %b%b%b%b, expected 0000", inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
        end
        n_checks++;
        if ({inst_rdata, data_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h, expected 0", inst_rdata, data_rdata);
        end
    endtask

    task automatic test_inst_only();
        inst_addr = 32'hBFC0_0000;
        for (int k = 0; k < 3; k++) begin
            drive(k == 0, 1'b0, k == 0, k == 1);
            n_checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr, mem_size, mem_wr} !==
                {(k == 0), (k == 0), 1'b0, (k == 0) ? inst_addr : 32'h0, (k == 0) ? SIZE_W : 2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL inst_only_addr[%0d]: got req=%b iok=%b dok=%b addr=%h size=%b", k, mem_req, inst_addr_ok, data_addr_ok, mem_addr, mem_size);
            end
            if (k == 0) sb_push(1'b0, 32'h1C00_0000);
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {(k == 1), 1'b0, (k == 1) ? 32'h1C00_0000 : 32'h0, 32'h0}) begin
                n_fail++;
                $display("FAIL inst_only_resp[%0d]: got ok=%b%b ir=%h dr=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic eid;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(k < 6, k < 6, k < 6, k > 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            eid = (k % 2 == 1);
`else
            eid = 1'b1;
`endif
            if (k < 6) begin
                n_checks++;
                if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {1'b1, !eid, eid, eid ? data_addr : inst_addr}) begin
                    n_fail++;
                    $display("FAIL b2b_grant[%0d]: got req=%b iok=%b dok=%b addr=%h, expected id=%b", k, mem_req, inst_addr_ok, data_addr_ok, mem_addr, eid);
                end
                sb_push(eid, 32'hB000_0000 + 32'(k));
            end
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {ex_i, ex_d, ex_i ? ex_r : 32'h0, ex_d ? ex_r : 32'h0}) begin
                n_fail++;
                $display("FAIL b2b_resp[%0d]: got ok=%b%b ir=%h dr=%h, expected ok=%b%b rdata=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ex_i, ex_d, ex_r);
            end
        end
    endtask

    task automatic test_lock();
        inst_addr = 32'h1C00_0200;
        data_addr = 32'h8000_0300;
        for (int k = 0; k < 6; k++) begin
            drive(k < 4, (k >= 1) && (k < 5), (k == 3) || (k == 4), k >= 4);
            if (k < 5) begin
                n_checks++;
                if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {1'b1, (k == 3), (k == 4), (k == 4) ? data_addr : inst_addr}) begin
                    n_fail++;
                    $display("FAIL lock_grant[%0d]: got req=%b iok=%b dok=%b addr=%h", k, mem_req, inst_addr_ok, data_addr_ok, mem_addr);
                end
            end
            if (k == 3) sb_push(1'b0, 32'hC0DE_0001);
            if (k == 4) sb_push(1'b1, 32'hC0DE_0002);
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {ex_i, ex_d, ex_i ? ex_r : 32'h0, ex_d ? ex_r : 32'h0}) begin
                n_fail++;
                $display("FAIL lock_resp[%0d]: got ok=%b%b ir=%h dr=%h, expected ok=%b%b rdata=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ex_i, ex_d, ex_r);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic exp_req;
        for (int k = 0; k < 7; k++) begin
            drive((k == 2) || (k == 3), k < 5, k < 5, k >= 3);
            exp_req = (k < 2) || (k == 4);
            n_checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !== {exp_req, 1'b0, exp_req}) begin
                n_fail++;
                $display("FAIL full_grant[%0d]: got req=%b iok=%b dok=%b, expected req=%b", k, mem_req, inst_addr_ok, data_addr_ok, exp_req);
            end
            if (exp_req) sb_push(1'b1, 32'hD000_0000 + 32'(k));
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {ex_i, ex_d, ex_i ? ex_r : 32'h0, ex_d ? ex_r : 32'h0}) begin
                n_fail++;
                $display("FAIL full_resp[%0d]: got ok=%b%b ir=%h dr=%h, expected ok=%b%b rdata=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ex_i, ex_d, ex_r);
            end
        end
    endtask

    task automatic test_write_order();
        data_wr = 1'b1; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF; data_size = SIZE_W;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) data_wr = 1'b0;
            drive(k == 1, k == 0, k < 2, k >= 2);
            if (k == 0) begin
                n_checks++;
                if ({mem_req, mem_wr, mem_wdata, mem_wstrb, mem_size, mem_addr, data_addr_ok, inst_addr_ok} !==
                    {1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, SIZE_W, data_addr, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL write_req: got wr=%b wdata=%h wstrb=%h addr=%h dok=%b", mem_wr, mem_wdata, mem_wstrb, mem_addr, data_addr_ok);
                end
                sb_push(1'b1, 32'h0BAD_F00D);
            end
            if (k == 1) begin
                n_checks++;
                if ({mem_req, mem_wr, mem_wdata, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 1'b0, 32'h0, inst_addr, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL write_then_read: got wr=%b wdata=%h addr=%h iok=%b", mem_wr, mem_wdata, mem_addr, inst_addr_ok);
                end
                sb_push(1'b0, 32'h1234_5678);
            end
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {ex_i, ex_d, ex_i ? ex_r : 32'h0, ex_d ? ex_r : 32'h0}) begin
                n_fail++;
                $display("FAIL order_resp[%0d]: got ok=%b%b ir=%h dr=%h, expected ok=%b%b rdata=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ex_i, ex_d, ex_r);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            sb_push(1'b1, 32'hEEEE_0000);
        end
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, (k == 1) || (k == 2), (k == 1) || (k == 2), (k == 0) || (k >= 3));
            if ((k == 1) || (k == 2)) begin
                n_checks++;
                if ({mem_req, data_addr_ok} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL post_reset_grant[%0d]: got req=%b dok=%b, expected 11", k, mem_req, data_addr_ok);
                end
                sb_push(1'b1, 32'hF000_0000 + 32'(k));
            end
            n_checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {ex_i, ex_d, ex_i ? ex_r : 32'h0, ex_d ? ex_r : 32'h0}) begin
                n_fail++;
                $display("FAIL post_reset_resp[%0d]: got ok=%b%b ir=%h dr=%h, expected ok=%b%b rdata=%h", k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ex_i, ex_d, ex_r);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        ex_i = 1'b0; ex_d = 1'b0; ex_r = '0;
        test_reset();
        test_inst_only();
        test_back_to_back();
        test_lock();
        test_fifo_full();
        test_write_order();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
